pipe_skid_reg: RTL and testbench

Stage-input pipeline register with a valid/ready handshake and a one-entry skid buffer, sitting between two stages of the pipelined MIPS datapath. It is the receiving end of a stage boundary. It accepts a word from the upstream stage, presents it to the downstream stage, and holds it without loss when downstream stalls. It gives full one-word-per-cycle throughput, and its upstream `in_ready` comes straight from a flop, so there is no combinational ready path across the stage.

---
 rtl/pipe_skid_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Receiving-side pipeline register for a stage boundary of the pipelined MIPS
// datapath. Words move in over a valid/ready handshake. The block holds at
// most two words: the presented word in `main_q` and one overflow word in
// `skid_q`. This gives full one-word-per-cycle throughput. in_ready is
// decoded only from the state register, so no combinational path runs from
// out_ready back to in_ready.
//
// Optional feature macro: PIPE_SKID_STATS_EN. When it is defined, the block
// adds the stall_cnt output, a saturating count of cycles that have
// out_valid && !out_ready.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset (overrides flush)
//   flush      synchronous squash; drops every held word
//   in_valid   upstream word available on in_data
//   in_ready   block can accept a word this cycle (from state flop)
//   in_data    upstream word [WL-1:0]
//   out_valid  out_data holds a valid word (from state flop)
//   out_ready  downstream consumes out_data this cycle
//   out_data   presented word [WL-1:0] (from main_q flop)
//   count      number of held words: 0, 1 or 2
//   stall_cnt  [15:0] saturating stall counter (PIPE_SKID_STATS_EN only)
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic [1:0]    count
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  // The state encoding equals the number of held words, so count is the
  // state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [WL-1:0] main_q, main_d;
  logic [WL-1:0] skid_q, skid_d;
  logic          in_fire, out_fire;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

  assign in_fire  = in_valid  && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal gets a hold default first so that no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;

    if (flush) begin
      // A flush beats any transfer. A word consumed this cycle still counts
      // as delivered, because downstream has already sampled out_data.
      state_next = EMPTY;
      main_d     = '0;
      skid_d     = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_d     = in_data;
            state_next = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;            // streaming: replace the word just consumed
          end else if (in_fire) begin
            skid_d     = in_data;        // main is stalled, so park the new word
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_fire) begin
            main_d     = skid_q;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          main_d     = '0;
          skid_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples the values from before the edge.
    if (RST) begin
      // NOTE: the data registers are reset as well, so out_data reads 0
      // after reset rather than stale contents.
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // Counts downstream-stall cycles. Only RST clears it; a flush does not.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Self-checking bench for pipe_skid_reg. The reference model treats the block
// as an ordered store that holds at most two words:
//  - a word enters when in_valid is high and fewer than two words are held;
//  - the oldest word leaves when a word is held and out_ready is high;
//  - flush and RST empty the store.
// The model process pushes each accepted word into exp_q at the clock edge.
// The monitor runs on the falling edge. It checks the DUT's flags and
// presented word against the store, and pops the store on every delivery.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int WL = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  logic [1:0]    count;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   stall_ref = '0;
`endif

  pipe_skid_reg #(.WL(WL)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          pre_size = 0;
  int          sz;
  bit          started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model update at the active edge. Inputs were driven #1 after
  // the previous edge, so they are stable here.
  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
      started = 1'b1;
`ifdef PIPE_SKID_STATS_EN
      stall_ref = '0;
`endif
    end else if (flush) begin
      exp_q.delete();
    end else if (started && in_valid && pre_size < 2) begin
      exp_q.push_back(in_data);
    end
  end

  // Monitor and scoreboard on the falling edge.
  always @(negedge CLK) begin
    if (started) begin
      sz       = exp_q.size();
      pre_size = sz;
      check("count",     32'(count),     32'(sz));
      check("in_ready",  32'(in_ready),  32'(sz < 2));
      check("out_valid", 32'(out_valid), 32'(sz > 0));
      if (sz > 0 && out_valid)
        check("out_data", out_data, exp_q[0]);
`ifdef PIPE_SKID_STATS_EN
      check("stall_cnt", 32'(stall_cnt), 32'(stall_ref));
      if (sz > 0 && !out_ready && stall_ref != 16'hFFFF)
        stall_ref = stall_ref + 16'd1;
`endif
      if (sz > 0 && out_ready)
        void'(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic fl, input logic iv,
                     input logic [31:0] d, input logic ordy);
    RST       = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_data"},  out_data,       32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
`ifdef PIPE_SKID_STATS_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles while upstream offers a word.
    cyc(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    check_reset_vals("reset");

    // Streaming: 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
      check("stream_count",    32'(count),    32'd1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_data",     out_data,      32'(i));
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stream_drain_count", 32'(count), 32'd0);

    // Backpressure: fill both entries, then offer a word while full.
    cyc(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    check("bp_count",    32'(count),    32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_data",     out_data,      32'hA);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
      check("bp_hold_data",  out_data,      32'hA);
      check("bp_hold_count", 32'(count),    32'd2);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_drain1_data", out_data, 32'hB);
    check("bp_in_ready_up", 32'(in_ready), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_drain2_count", 32'(count), 32'd0);

    // Flush while full; the word offered on the flush cycle is dropped.
    cyc(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'hC,  1'b0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_count",     32'(count),     32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    check("flush_out_data",  out_data,       32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("flush_no_deliver", 32'(out_valid), 32'd0);
    end

    // RST together with flush while full.
    cyc(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    cyc(1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
    check_reset_vals("rst_flush");

    // Stall counting: five stalled cycles, then a delivering flush.
    cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_SKID_STATS_EN
    check("stats_after_stall", 32'(stall_cnt), 32'd5);
`endif
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef PIPE_SKID_STATS_EN
    check("stats_after_flush", 32'(stall_cnt), 32'd5);
`endif
    check("stats_flush_out_valid", 32'(out_valid), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'b0,
          ($urandom_range(99) < 3),
          ($urandom_range(99) < 65),
          $urandom,
          ($urandom_range(99) < 60));
    end
    // Drain what is left.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
